instruction_fetch_unit: RTL and testbench

- Owns the program counter and fetches instructions from instruction ROM over a req/ack handshake.
- Presents a stable instruction word and pc_next to the datapath and control FSM directly downstream.
- The control FSM drives fetch_req (its ROM-select phase) and pc_write (its write-back phase). This block decides the next PC: sequential or branch target.

---
 rtl/instruction_fetch_unit_if.sv | 28 ++
 rtl/instruction_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Signal bundle between the instruction fetch unit, the control FSM/datapath and the instruction ROM.
// The fetch unit connects through the slave modport; the control/ROM side uses the master modport.
interface instruction_fetch_unit_if;
  logic        fetch_req;
  logic        pc_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        rom_req;
  logic [31:0] rom_address;
  logic        rom_ack;
  logic [31:0] rom_data;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        inst_valid;
  logic        fetch_busy;
  logic        fetch_error;

  modport master (
    output fetch_req, pc_write, branch_taken, branch_target, rom_ack, rom_data,
    input  rom_req, rom_address, instruction, pc, pc_next, inst_valid, fetch_busy, fetch_error
  );

  modport slave (
    input  fetch_req, pc_write, branch_taken, branch_target, rom_ack, rom_data,
    output rom_req, rom_address, instruction, pc, pc_next, inst_valid, fetch_busy, fetch_error
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Program counter owner and ROM fetch sequencer: fetches over a req/ack handshake with
// timeout, holds the instruction for the datapath, and applies sequential/branch PC updates.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic                     clk,
  input logic                     reset,
  instruction_fetch_unit_if.slave bus
);

  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [31:0] pc_inc;
  logic        misaligned;

  assign pc_inc     = pc_q + 32'd4;
  assign misaligned = bus.branch_taken && (bus.branch_target[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_VECTOR;
      instr_q <= NOP_INSN;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.pc_write) err_d = 1'b1;
        if (bus.fetch_req) begin
          state_d = S_REQ;
          cnt_d   = 8'd0;
        end
      end

      S_REQ: begin
        // A stray pc_write only flags the error; the outstanding fetch still completes.
        if (bus.pc_write) err_d = 1'b1;
        if (bus.rom_ack) begin
          instr_d = bus.rom_data;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TIMEOUT_LAST) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (bus.pc_write) begin
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = S_ERROR;
          end else begin
            pc_d    = bus.branch_taken ? bus.branch_target : pc_inc;
            valid_d = 1'b0;
            // Combined write-back and fetch: the new PC is what the REQ phase presents.
            if (bus.fetch_req) begin
              state_d = S_REQ;
              cnt_d   = 8'd0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (bus.fetch_req) begin
          state_d = S_REQ;
          cnt_d   = 8'd0;
        end
      end

      S_ERROR: begin
        state_d = S_ERROR;
      end

      default: begin
        state_d = S_ERROR;
        err_d   = 1'b1;
      end
    endcase
  end

  assign bus.rom_req     = (state_q == S_REQ);
  assign bus.rom_address = pc_q;
  assign bus.fetch_busy  = (state_q == S_REQ);
  assign bus.instruction = instr_q;
  assign bus.pc          = pc_q;
  assign bus.pc_next     = pc_inc;
  assign bus.inst_valid  = valid_q;
  assign bus.fetch_error = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a transaction-level reference model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam int          TMO = 15;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic reset;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_VECTOR  (RV),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        fr;
    logic        pw;
    logic        bt;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] data;
    logic        e_req;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_err;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mv(logic fr, logic pw, logic bt, logic [31:0] tgt, logic ack,
                              logic [31:0] data, logic e_req, logic [31:0] e_pc,
                              logic [31:0] e_instr, logic e_valid, logic e_err);
    vec_t v;
    v.fr = fr; v.pw = pw; v.bt = bt; v.tgt = tgt; v.ack = ack; v.data = data;
    v.e_req = e_req; v.e_pc = e_pc; v.e_instr = e_instr; v.e_valid = e_valid; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample 1ns after the rising edge.
  task automatic step(input logic fr, input logic pw, input logic bt, input logic [31:0] tgt,
                      input logic ack, input logic [31:0] data);
    bus.fetch_req     = fr;
    bus.pc_write      = pw;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    bus.rom_ack       = ack;
    bus.rom_data      = data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic fetch_ok(input logic [31:0] data);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, data);
  endtask

  task automatic branch(input logic [31:0] tgt);
    step(1'b0, 1'b1, 1'b1, tgt, 1'b0, 32'h0);
  endtask

  // Reference model: tracks what the fetch unit owes the datapath, in transaction terms.
  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_err;
  logic        m_waiting, m_have_insn, m_dead;
  int          m_misses;

  task automatic m_reset();
    m_pc = RV; m_instr = NOP; m_valid = 1'b0; m_err = 1'b0;
    m_waiting = 1'b0; m_have_insn = 1'b0; m_dead = 1'b0; m_misses = 0;
  endtask

  task automatic m_start_fetch();
    m_waiting   = 1'b1;
    m_have_insn = 1'b0;
    m_misses    = 0;
  endtask

  task automatic m_update(input logic fr, input logic pw, input logic bt, input logic [31:0] tgt,
                          input logic ack, input logic [31:0] data);
    if (m_dead) return;
    if (m_waiting) begin
      if (pw) m_err = 1'b1;
      if (ack) begin
        m_instr = data; m_valid = 1'b1; m_waiting = 1'b0; m_have_insn = 1'b1;
      end else begin
        m_misses++;
        if (m_misses >= TMO) begin
          m_dead = 1'b1; m_waiting = 1'b0; m_err = 1'b1;
        end
      end
    end else if (m_have_insn) begin
      if (pw) begin
        if (bt && (tgt % 4 != 0)) begin
          m_err = 1'b1; m_dead = 1'b1; m_have_insn = 1'b0;
        end else begin
          m_pc = bt ? tgt : m_pc + 32'd4;
          m_valid = 1'b0;
          m_have_insn = 1'b0;
          if (fr) m_start_fetch();
        end
      end else if (fr) begin
        m_start_fetch();
      end
    end else begin
      if (pw) m_err = 1'b1;
      if (fr) m_start_fetch();
    end
  endtask

  task automatic m_check(input string tag);
    chk({tag, ".rom_req"}, 32'(bus.rom_req), 32'(m_waiting));
    chk({tag, ".busy"}, 32'(bus.fetch_busy), 32'(m_waiting));
    chk({tag, ".pc"}, bus.pc, m_pc);
    chk({tag, ".pc_next"}, bus.pc_next, m_pc + 32'd4);
    if (m_waiting) chk({tag, ".rom_address"}, bus.rom_address, m_pc);
    chk({tag, ".instruction"}, bus.instruction, m_instr);
    chk({tag, ".inst_valid"}, 32'(bus.inst_valid), 32'(m_valid));
    chk({tag, ".fetch_error"}, 32'(bus.fetch_error), 32'(m_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.fetch_req = 1'b0; bus.pc_write = 1'b0; bus.branch_taken = 1'b0;
    bus.branch_target = 32'h0; bus.rom_ack = 1'b0; bus.rom_data = 32'h0;
    reset = 1'b0;
    #12;
    chk("rst.pc", bus.pc, RV);
    chk("rst.instruction", bus.instruction, NOP);
    chk("rst.inst_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst.rom_req", 32'(bus.rom_req), 32'h0);
    chk("rst.busy", 32'(bus.fetch_busy), 32'h0);
    chk("rst.fetch_error", 32'(bus.fetch_error), 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table.
    vecs[0]  = mv(1, 0, 0, 32'h0,   0, 32'h0,         1, 32'h0,   NOP,           0, 0);
    vecs[1]  = mv(0, 0, 0, 32'h0,   0, 32'h0,         1, 32'h0,   NOP,           0, 0);
    vecs[2]  = mv(0, 0, 0, 32'h0,   0, 32'h0,         1, 32'h0,   NOP,           0, 0);
    vecs[3]  = mv(0, 0, 0, 32'h0,   1, 32'h0050_0093, 0, 32'h0,   32'h0050_0093, 1, 0);
    vecs[4]  = mv(0, 1, 0, 32'h0,   0, 32'h0,         0, 32'h4,   32'h0050_0093, 0, 0);
    vecs[5]  = mv(1, 0, 0, 32'h0,   0, 32'h0,         1, 32'h4,   32'h0050_0093, 0, 0);
    vecs[6]  = mv(0, 0, 0, 32'h0,   1, 32'hAAAA_5554, 0, 32'h4,   32'hAAAA_5554, 1, 0);
    vecs[7]  = mv(1, 1, 1, 32'h100, 0, 32'h0,         1, 32'h100, 32'hAAAA_5554, 0, 0);
    vecs[8]  = mv(0, 0, 0, 32'h0,   1, 32'h1234_5678, 0, 32'h100, 32'h1234_5678, 1, 0);
    vecs[9]  = mv(0, 1, 0, 32'h0,   0, 32'h0,         0, 32'h104, 32'h1234_5678, 0, 0);
    vecs[10] = mv(0, 1, 0, 32'h0,   0, 32'h0,         0, 32'h104, 32'h1234_5678, 0, 1);
    vecs[11] = mv(1, 0, 0, 32'h0,   0, 32'h0,         1, 32'h104, 32'h1234_5678, 0, 1);
    vecs[12] = mv(0, 0, 0, 32'h0,   1, 32'hDEAD_BEEF, 0, 32'h104, 32'hDEAD_BEEF, 1, 1);
    vecs[13] = mv(0, 0, 0, 32'h0,   1, 32'h0000_0BAD, 0, 32'h104, 32'hDEAD_BEEF, 1, 1);

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].fr, vecs[i].pw, vecs[i].bt, vecs[i].tgt, vecs[i].ack, vecs[i].data);
      chk($sformatf("vec%0d.rom_req", i), 32'(bus.rom_req), 32'(vecs[i].e_req));
      chk($sformatf("vec%0d.busy", i), 32'(bus.fetch_busy), 32'(vecs[i].e_req));
      chk($sformatf("vec%0d.pc", i), bus.pc, vecs[i].e_pc);
      chk($sformatf("vec%0d.pc_next", i), bus.pc_next, vecs[i].e_pc + 32'd4);
      if (vecs[i].e_req) chk($sformatf("vec%0d.rom_address", i), bus.rom_address, vecs[i].e_pc);
      chk($sformatf("vec%0d.instruction", i), bus.instruction, vecs[i].e_instr);
      chk($sformatf("vec%0d.inst_valid", i), 32'(bus.inst_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.fetch_error", i), 32'(bus.fetch_error), 32'(vecs[i].e_err));
    end

    // Sequential then branch update from HOLD at pc=0x10.
    pulse_reset();
    fetch_ok(32'h1);
    branch(32'h10);
    fetch_ok(32'h2);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("seq.pc", bus.pc, 32'h14);
    chk("seq.inst_valid", 32'(bus.inst_valid), 32'h0);
    chk("seq.rom_req", 32'(bus.rom_req), 32'h0);
    fetch_ok(32'h3);
    branch(32'h100);
    chk("br.pc", bus.pc, 32'h100);
    chk("br.fetch_error", 32'(bus.fetch_error), 32'h0);

    // pc_write and fetch_req together in HOLD at pc=0x20.
    fetch_ok(32'h4);
    branch(32'h20);
    fetch_ok(32'h5);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("both.rom_req", 32'(bus.rom_req), 32'h1);
    chk("both.rom_address", bus.rom_address, 32'h24);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h6);
    chk("both.instruction", bus.instruction, 32'h6);

    // Misaligned redirect: terminal error.
    branch(32'h102);
    chk("mis.pc", bus.pc, 32'h24);
    chk("mis.fetch_error", 32'(bus.fetch_error), 32'h1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("mis.fr_ignored", 32'(bus.rom_req), 32'h0);
    branch(32'h200);
    chk("mis.pw_ignored", bus.pc, 32'h24);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h77);
    chk("mis.rom_req_late", 32'(bus.rom_req), 32'h0);
    chk("mis.instruction", bus.instruction, 32'h6);

    // ROM never acknowledges.
    pulse_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n = 0;
    while (bus.rom_req && n < 40) begin
      n++;
      idle();
    end
    chk("tmo.req_cycles", 32'(n), 32'(TMO));
    chk("tmo.fetch_error", 32'(bus.fetch_error), 32'h1);
    chk("tmo.rom_req", 32'(bus.rom_req), 32'h0);

    // PC wrap at the top of the address space.
    pulse_reset();
    fetch_ok(32'h8);
    branch(32'hFFFF_FFFC);
    fetch_ok(32'h9);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("wrap.pc", bus.pc, 32'h0);
    chk("wrap.fetch_error", 32'(bus.fetch_error), 32'h0);

    // Reset asserted while a fetch is outstanding.
    fetch_ok(32'hA);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rreq.pre_req", 32'(bus.rom_req), 32'h1);
    reset = 1'b0;
    #1;
    chk("rreq.rom_req", 32'(bus.rom_req), 32'h0);
    chk("rreq.pc", bus.pc, RV);
    chk("rreq.instruction", bus.instruction, NOP);
    #1;
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h55);
    chk("rreq.idle_ack_ignored", bus.instruction, NOP);
    chk("rreq.post_rom_req", 32'(bus.rom_req), 32'h0);
    chk("rreq.post_valid", 32'(bus.inst_valid), 32'h0);

    // Randomized traffic against the reference model.
    pulse_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        fr, pw, bt, ack;
      logic [31:0] tgt, data;
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        #1;
        chk("rand.reset_rom_req", 32'(bus.rom_req), 32'h0);
        m_reset();
        #1;
        reset = 1'b1;
      end
      fr   = ($urandom_range(0, 2) == 0);
      pw   = ($urandom_range(0, 2) == 0);
      bt   = $urandom_range(0, 1) == 1;
      tgt  = $urandom;
      if ($urandom_range(0, 15) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFFC;
      ack  = ($urandom_range(0, 3) == 0);
      data = $urandom;
      step(fr, pw, bt, tgt, ack, data);
      m_update(fr, pw, bt, tgt, ack, data);
      m_check($sformatf("rand%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
